// File: rtl/decodificador_pkg.sv
// Shared operation codes, FSM state encoding and latency selection
// for the sequenced operation decoder.
package decodificador_pkg;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DESPACHO,
        ESPERA,
        INVALIDA
    } estado_t;

    typedef enum logic [1:0] {
        LAT_SEL_BASE,
        LAT_SEL_MUL,
        LAT_SEL_DIV
    } lat_sel_t;

    function automatic lat_sel_t lat_operacao(input int unsigned codigo);
        if (codigo == 32'(OP_MUL))
            return LAT_SEL_MUL;
        if (codigo == 32'(OP_DIV))
            return LAT_SEL_DIV;
        return LAT_SEL_BASE;
    endfunction

endpackage

// File: rtl/decodificador_operacoes_seq_contador_latencia.sv
// Loadable down-counter with zero flag; holds at zero.
module contador_latencia #(
    parameter int LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carregar,
    input  logic               decrementar,
    input  logic [LARGURA-1:0] valor_carga,
    output logic               zero
);
    logic [LARGURA-1:0] contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            contagem <= '0;
        else if (carregar)
            contagem <= valor_carga;
        else if (decrementar && contagem != '0)
            contagem <= contagem - 1'b1;
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/decodificador_operacoes_seq.sv
// Sequenced operation decoder with per-operation ULA latency.
// Optional saturating invalid-word counter: DECOD_CONTADOR_ERROS_EN.
module decodificador_operacoes_seq
    import decodificador_pkg::*;
#(
    parameter int LARGURA_ENTRADA = 8,
    parameter int LARGURA_CODIGO  = 3,
    parameter int LAT_BASE        = 1,
    parameter int LAT_MUL         = 4,
    parameter int LAT_DIV         = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         entrada_valida,
    input  logic [LARGURA_ENTRADA-1:0]   operacao,
    output logic                         entrada_pronta,
    output logic                         saida_valida,
    output logic [LARGURA_CODIGO-1:0]    codigo_operacao,
    output logic [2**LARGURA_CODIGO-1:0] operacao_onehot,
    output logic                         operacao_invalida,
    output logic                         ula_ocupada,
`ifdef DECOD_CONTADOR_ERROS_EN
    output logic                         ula_concluida,
    output logic [7:0]                   contagem_erros
`else
    output logic                         ula_concluida
`endif
);
    localparam int LARGURA_OH = 2**LARGURA_CODIGO;
    localparam int LAT_MAX_BM = (LAT_BASE > LAT_MUL) ? LAT_BASE : LAT_MUL;
    localparam int LAT_MAX    = (LAT_MAX_BM > LAT_DIV) ? LAT_MAX_BM : LAT_DIV;
    localparam int LARGURA_CNT = $clog2(LAT_MAX + 1);

    localparam logic [LARGURA_CNT-1:0] CARGA_BASE = LARGURA_CNT'(LAT_BASE - 1);
    localparam logic [LARGURA_CNT-1:0] CARGA_MUL  = LARGURA_CNT'(LAT_MUL - 1);
    localparam logic [LARGURA_CNT-1:0] CARGA_DIV  = LARGURA_CNT'(LAT_DIV - 1);

    estado_t estado, estado_prox;

    logic                      aceita;
    logic                      palavra_invalida;
    logic [LARGURA_CODIGO-1:0] codigo_in;
    logic [LARGURA_CNT-1:0]    carga;
    logic                      cnt_zero;
    logic                      fim_espera;

    assign codigo_in        = operacao[LARGURA_CODIGO-1:0];
    assign palavra_invalida = |operacao[LARGURA_ENTRADA-1:LARGURA_CODIGO];
    assign aceita           = entrada_valida && (estado == IDLE);
    assign fim_espera       = (estado == ESPERA) && cnt_zero;

    always_comb begin
        carga = CARGA_BASE;
        unique case (lat_operacao(32'(codigo_in)))
            LAT_SEL_MUL: carga = CARGA_MUL;
            LAT_SEL_DIV: carga = CARGA_DIV;
            default:     carga = CARGA_BASE;
        endcase
    end

    contador_latencia #(
        .LARGURA(LARGURA_CNT)
    ) u_contador (
        .clk        (clk),
        .rst_n      (rst_n),
        .carregar   (aceita && !palavra_invalida),
        .decrementar(estado == ESPERA),
        .valor_carga(carga),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            estado <= IDLE;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox       = estado;
        entrada_pronta    = 1'b0;
        saida_valida      = 1'b0;
        operacao_invalida = 1'b0;
        ula_ocupada       = 1'b0;
        ula_concluida     = 1'b0;
        unique case (estado)
            IDLE: begin
                entrada_pronta = 1'b1;
                if (entrada_valida)
                    estado_prox = palavra_invalida ? INVALIDA : DESPACHO;
            end
            DESPACHO: begin
                saida_valida = 1'b1;
                ula_ocupada  = 1'b1;
                estado_prox  = ESPERA;
            end
            ESPERA: begin
                ula_ocupada = 1'b1;
                if (cnt_zero) begin
                    ula_concluida = 1'b1;
                    estado_prox   = IDLE;
                end
            end
            INVALIDA: begin
                saida_valida      = 1'b1;
                operacao_invalida = 1'b1;
                estado_prox       = IDLE;
            end
            default: estado_prox = IDLE;
        endcase
    end

    // Code survives until the next accept; one-hot drops when ULA finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codigo_operacao <= '0;
            operacao_onehot <= '0;
        end else if (aceita) begin
            if (palavra_invalida) begin
                codigo_operacao <= '0;
                operacao_onehot <= '0;
            end else begin
                codigo_operacao <= codigo_in;
                operacao_onehot <= LARGURA_OH'(1) << codigo_in;
            end
        end else if (fim_espera) begin
            operacao_onehot <= '0;
        end
    end

`ifdef DECOD_CONTADOR_ERROS_EN
    logic [7:0] erros;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            erros <= '0;
        else if (aceita && palavra_invalida && erros != 8'hFF)
            erros <= erros + 8'd1;
    end

    assign contagem_erros = erros;
`endif

endmodule

// File: tb/tb_decodificador_operacoes_seq.sv
// Directed self-checking bench for decodificador_operacoes_seq.
module tb_decodificador_operacoes_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entrada_valida = 1'b0;
    logic [7:0] operacao = 8'h00;
    logic       entrada_pronta;
    logic       saida_valida;
    logic [2:0] codigo_operacao;
    logic [7:0] operacao_onehot;
    logic       operacao_invalida;
    logic       ula_ocupada;
    logic       ula_concluida;
`ifdef DECOD_CONTADOR_ERROS_EN
    logic [7:0] contagem_erros;
`endif

    int total = 0;
    int falhas = 0;
    int erros_esp = 0;

    always #5 clk = ~clk;

    decodificador_operacoes_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .entrada_valida   (entrada_valida),
        .operacao         (operacao),
        .entrada_pronta   (entrada_pronta),
        .saida_valida     (saida_valida),
        .codigo_operacao  (codigo_operacao),
        .operacao_onehot  (operacao_onehot),
        .operacao_invalida(operacao_invalida),
        .ula_ocupada      (ula_ocupada),
`ifdef DECOD_CONTADOR_ERROS_EN
        .ula_concluida    (ula_concluida),
        .contagem_erros   (contagem_erros)
`else
        .ula_concluida    (ula_concluida)
`endif
    );

    // Drive one word so that it is accepted at the next rising edge;
    // returns #1 after that edge (cycle k=0 after accept).
    task automatic aceitar(input logic [7:0] op, input bit manter);
        @(negedge clk);
        entrada_valida = 1'b1;
        operacao = op;
        @(posedge clk);
        #1;
        if (!manter) entrada_valida = 1'b0;
    endtask

    task automatic proximo();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            entrada_valida = 1'($urandom_range(0, 1));
            operacao = 8'($urandom_range(0, 255));
        end
        #1;
        total++;
        if ({entrada_pronta, saida_valida, codigo_operacao, operacao_onehot,
             operacao_invalida, ula_ocupada, ula_concluida} !== {1'b1, 15'h0}) begin
            falhas++;
            $display("FAIL reset: pronta=%b sv=%b cod=%h oh=%h inv=%b ocup=%b conc=%b required pronta=1 rest 0",
                     entrada_pronta, saida_valida, codigo_operacao, operacao_onehot,
                     operacao_invalida, ula_ocupada, ula_concluida);
        end
`ifdef DECOD_CONTADOR_ERROS_EN
        total++;
        if (contagem_erros !== 8'd0) begin
            falhas++;
            $display("FAIL reset_erros: got %0d required 0", contagem_erros);
        end
`endif
        @(negedge clk);
        entrada_valida = 1'b0;
        operacao = 8'h00;
        rst_n = 1'b1;
        proximo();
        total++;
        if (entrada_pronta !== 1'b1 || ula_ocupada !== 1'b0) begin
            falhas++;
            $display("FAIL reset_release: pronta=%b ocup=%b required 1 0", entrada_pronta, ula_ocupada);
        end
    endtask

    // Valid word with expected latency lat: saida_valida at k=0,
    // ESPERA for k=1..lat with concluida at k=lat, IDLE at k=lat+1.
    task automatic test_valida(input logic [7:0] op, input int lat, input bit manter);
        logic [2:0] cod;
        logic [7:0] oh;
        cod = op[2:0];
        oh = 8'h01 << cod;
        aceitar(op, manter);
        if (manter) operacao = 8'h01;
        total++;
        if (saida_valida !== 1'b1 || codigo_operacao !== cod || operacao_onehot !== oh
            || entrada_pronta !== 1'b0 || operacao_invalida !== 1'b0 || ula_ocupada !== 1'b1) begin
            falhas++;
            $display("FAIL despacho_%h: sv=%b cod=%h oh=%h pronta=%b inv=%b ocup=%b required 1 %h %h 0 0 1",
                     op, saida_valida, codigo_operacao, operacao_onehot, entrada_pronta,
                     operacao_invalida, ula_ocupada, cod, oh);
        end
        for (int k = 1; k <= lat; k++) begin
            proximo();
            total++;
            if (saida_valida !== 1'b0 || ula_ocupada !== 1'b1 || entrada_pronta !== 1'b0
                || ula_concluida !== (k == lat) || codigo_operacao !== cod || operacao_onehot !== oh) begin
                falhas++;
                $display("FAIL espera_%h_k%0d: sv=%b ocup=%b pronta=%b conc=%b cod=%h oh=%h required 0 1 0 %b %h %h",
                         op, k, saida_valida, ula_ocupada, entrada_pronta, ula_concluida,
                         codigo_operacao, operacao_onehot, k == lat, cod, oh);
            end
        end
        proximo();
        total++;
        if (entrada_pronta !== 1'b1 || ula_ocupada !== 1'b0 || ula_concluida !== 1'b0
            || operacao_onehot !== 8'h00 || codigo_operacao !== cod) begin
            falhas++;
            $display("FAIL idle_%h: pronta=%b ocup=%b conc=%b oh=%h cod=%h required 1 0 0 00 %h",
                     op, entrada_pronta, ula_ocupada, ula_concluida, operacao_onehot,
                     codigo_operacao, cod);
        end
        @(negedge clk);
        entrada_valida = 1'b0;
        operacao = 8'h00;
    endtask

    task automatic test_invalida(input logic [7:0] op);
        aceitar(op, 1'b0);
        erros_esp = (erros_esp < 255) ? erros_esp + 1 : 255;
        total++;
        if (saida_valida !== 1'b1 || operacao_invalida !== 1'b1 || operacao_onehot !== 8'h00
            || codigo_operacao !== 3'b000 || ula_ocupada !== 1'b0 || ula_concluida !== 1'b0) begin
            falhas++;
            $display("FAIL invalida_%h: sv=%b inv=%b oh=%h cod=%h ocup=%b conc=%b required 1 1 00 0 0 0",
                     op, saida_valida, operacao_invalida, operacao_onehot, codigo_operacao,
                     ula_ocupada, ula_concluida);
        end
`ifdef DECOD_CONTADOR_ERROS_EN
        total++;
        if (contagem_erros !== 8'(erros_esp)) begin
            falhas++;
            $display("FAIL erros_%h: got %0d required %0d", op, contagem_erros, erros_esp);
        end
`endif
        proximo();
        total++;
        if (entrada_pronta !== 1'b1 || saida_valida !== 1'b0 || operacao_invalida !== 1'b0
            || ula_concluida !== 1'b0) begin
            falhas++;
            $display("FAIL invalida_idle_%h: pronta=%b sv=%b inv=%b conc=%b required 1 0 0 0",
                     op, entrada_pronta, saida_valida, operacao_invalida, ula_concluida);
        end
    endtask

    task automatic test_reset_abort();
        int pulsos;
        aceitar(8'h02, 1'b0);
        proximo();
        proximo();
        rst_n = 1'b0;
        erros_esp = 0;
        #1;
        total++;
        if (ula_ocupada !== 1'b0 || entrada_pronta !== 1'b1 || saida_valida !== 1'b0
            || codigo_operacao !== 3'b000 || operacao_onehot !== 8'h00) begin
            falhas++;
            $display("FAIL abort: ocup=%b pronta=%b sv=%b cod=%h oh=%h required 0 1 0 0 00",
                     ula_ocupada, entrada_pronta, saida_valida, codigo_operacao, operacao_onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulsos = 0;
        for (int i = 0; i < 8; i++) begin
            proximo();
            if (ula_concluida !== 1'b0 || ula_ocupada !== 1'b0) pulsos++;
        end
        total++;
        if (pulsos != 0) begin
            falhas++;
            $display("FAIL abort_concluida: %0d active cycles required 0", pulsos);
        end
    endtask

`ifdef DECOD_CONTADOR_ERROS_EN
    task automatic test_saturacao();
        @(negedge clk);
        entrada_valida = 1'b1;
        operacao = 8'hF0;
        for (int i = 0; i < 520; i++) @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        proximo();
        proximo();
        total++;
        if (contagem_erros !== 8'd255) begin
            falhas++;
            $display("FAIL saturacao: got %0d required 255", contagem_erros);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_valida(8'h00, 1, 1'b0);
        test_valida(8'h03, 8, 1'b1);
        test_valida(8'h02, 4, 1'b0);
        test_valida(8'h04, 1, 1'b0);
        test_valida(8'h07, 1, 1'b0);
        test_invalida(8'h25);
        test_invalida(8'h80);
        test_valida(8'h01, 1, 1'b0);
        test_reset_abort();
        test_valida(8'h05, 1, 1'b0);
`ifdef DECOD_CONTADOR_ERROS_EN
        test_saturacao();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", total, falhas);
        $finish;
    end

endmodule
